sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 143 ++++++++++++++
 tb/tb_sar_search.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search that drives an external comparator to find an unknown target.
// A search of p probes raises done 2p edges after start is sampled; start is ignored while busy.
module sar_search #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] guess,
  input  logic         aeb,
  input  logic         agb,
  input  logic         alb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic [3:0]   probes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // One extra bit so hi = 2^W-1 plus lo cannot wrap, and guess+1 at the top stays exact.
  logic [W:0] lo;
  logic [W:0] hi;
  logic [W:0] guess_ext;
  logic [W:0] sum;
  logic [W:0] one_ext;

  logic found;
  logic fail;
  logic shrink_hi;
  logic raise_lo;

  assign one_ext   = {{W{1'b0}}, 1'b1};
  assign guess_ext = {1'b0, guess};
  assign sum       = lo + hi;
  assign busy      = (state == PROBE) || (state == EVAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    found     = 1'b0;
    fail      = 1'b0;
    shrink_hi = 1'b0;
    raise_lo  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PROBE;
        end
      end
      PROBE: begin
        state_nxt = EVAL;
      end
      EVAL: begin
        // A comparator that is not one-hot can't be trusted, so the search aborts.
        case ({aeb, agb, alb})
          3'b100: found = 1'b1;
          3'b010: begin
            if (guess_ext == lo) begin
              fail = 1'b1;
            end else begin
              shrink_hi = 1'b1;
            end
          end
          3'b001: begin
            if (guess_ext == hi) begin
              fail = 1'b1;
            end else begin
              raise_lo = 1'b1;
            end
          end
          default: fail = 1'b1;
        endcase
        state_nxt = (found || fail) ? IDLE : PROBE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess  <= '0;
      lo     <= '0;
      hi     <= '0;
      result <= '0;
      probes <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= {1'b0, {W{1'b1}}};
            probes <= '0;
            err    <= 1'b0;
          end
        end
        PROBE: begin
          guess <= sum[W:1];
        end
        EVAL: begin
          probes <= probes + 4'd1;
          if (found) begin
            result <= guess;
            done   <= 1'b1;
          end
          if (fail) begin
            err  <= 1'b1;
            done <= 1'b1;
          end
          if (shrink_hi) begin
            hi <= guess_ext - one_ext;
          end
          if (raise_lo) begin
            lo <= guess_ext + one_ext;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (W=8) against a behavioural comparator with flag override.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] guess;
  logic       aeb, agb, alb;
  logic       busy, done, err;
  logic [7:0] result;
  logic [3:0] probes;

  logic [7:0] target;
  logic       ovr;
  logic [2:0] ovr_flags;

  int compared;
  int mismatched;
  int exp_seq[$];

  sar_search #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .guess  (guess),
    .aeb    (aeb),
    .agb    (agb),
    .alb    (alb),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .probes (probes)
  );

  assign {aeb, agb, alb} = ovr ? ovr_flags
                               : {guess == target, guess > target, guess < target};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one search whose guesses must follow exp_seq; start is re-pulsed ahead of edge restart_at.
  task automatic run_search(input string tag, input logic [7:0] tgt, input int restart_at,
                            input logic exp_err, input logic [7:0] exp_res);
    int n;
    n = exp_seq.size();
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_probes_clr"}, probes, 0);
    for (int i = 0; i < n; i++) begin
      start = ((2 * i + 1) == restart_at);
      step();
      start = 1'b0;
      chk($sformatf("%s_guess%0d", tag, i), guess, exp_seq[i]);
      start = ((2 * i + 2) == restart_at);
      step();
      start = 1'b0;
      if (i == n - 1) begin
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_probes"}, probes, n);
        chk({tag, "_idle"}, busy, 0);
      end else begin
        chk($sformatf("%s_nodone%0d", tag, i), done, 0);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    target     = 8'd0;
    ovr        = 1'b0;
    ovr_flags  = 3'b000;

    #12;
    chk("rst_guess", guess, 0);
    chk("rst_result", result, 0);
    chk("rst_probes", probes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Target at the first midpoint: one probe.
    exp_seq = '{127};
    run_search("t127", 8'd127, -1, 1'b0, 8'd127);
    step();
    chk("t127_done_pulse", done, 0);
    chk("t127_guess_hold", guess, 127);

    // Both aeb and agb: aborts on first EVAL, result keeps 127.
    ovr = 1'b1;
    ovr_flags = 3'b110;
    exp_seq = '{127};
    run_search("multi", 8'd50, -1, 1'b1, 8'd127);
    // No flags at all also aborts.
    ovr_flags = 3'b000;
    run_search("none", 8'd50, -1, 1'b1, 8'd127);
    ovr = 1'b0;

    exp_seq = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("t0", 8'd0, -1, 1'b0, 8'd0);

    exp_seq = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("t255", 8'd255, -1, 1'b0, 8'd255);

    // Comparator always says "less": runs into the top bound and reports err.
    ovr = 1'b1;
    ovr_flags = 3'b001;
    run_search("lt_top", 8'd0, -1, 1'b1, 8'd255);
    ovr = 1'b0;

    // Start re-pulsed mid-search is ignored.
    exp_seq = '{127, 191, 223, 207, 199, 203, 201, 200};
    run_search("t200", 8'd200, 4, 1'b0, 8'd200);

    // Start in the done cycle begins a new search straight away.
    chk("b2b_done_cycle", done, 1);
    target = 8'd127;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_err_clr", err, 0);
    step();
    chk("b2b_guess", guess, 127);
    step();
    chk("b2b_done", done, 1);
    chk("b2b_result", result, 127);
    step();
    chk("b2b_idle", busy, 0);

    // Reset asserted while in the third EVAL.
    target = 8'd100;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_guess", guess, 0);
    chk("mid_result", result, 0);
    chk("mid_probes", probes, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    step();
    chk("mid_no_done", done, 0);
    rst_n = 1'b1;
    #2;
    exp_seq = '{127, 63, 31, 15, 7, 3, 5};
    run_search("t5", 8'd5, -1, 1'b0, 8'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
